// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel (AR + R) between the icache (S0) and the dcache (S1),
// one burst at a time, with a sticky check of received beats against ARLEN+1.
module axi_read_arbiter #(
    parameter bit         RR_MODE = 1'b1,
    parameter logic [3:0] S0_ID   = 4'd0,
    parameter logic [3:0] S1_ID   = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] s0_araddr,
    input  logic [7:0]  s0_arlen,
    input  logic [1:0]  s0_arburst,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    output logic [31:0] s0_rdata,
    output logic        s0_rlast,
    output logic        s0_rvalid,
    input  logic        s0_rready,

    input  logic [31:0] s1_araddr,
    input  logic [7:0]  s1_arlen,
    input  logic [1:0]  s1_arburst,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    output logic [31:0] s1_rdata,
    output logic        s1_rlast,
    output logic        s1_rvalid,
    input  logic        s1_rready,

    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [1:0]  m_arburst,
    output logic [2:0]  m_arsize,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,

    output logic        busy,
    output logic        protocol_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        grant;
    logic        last_grant;
    logic [7:0]  beat_cnt;
    logic [7:0]  len_reg;

    logic        sel_arvalid;
    logic        sel_rready;
    logic [7:0]  sel_arlen;
    logic        pick;
    logic        ar_hs;
    logic        beat;

    assign sel_arvalid = grant ? s1_arvalid : s0_arvalid;
    assign sel_rready  = grant ? s1_rready  : s0_rready;
    assign sel_arlen   = grant ? s1_arlen   : s0_arlen;

    // On a tie, round-robin favours whoever was not served last; fixed mode favours the dcache.
    assign pick  = (s0_arvalid && s1_arvalid) ? (RR_MODE ? ~last_grant : 1'b1) : s1_arvalid;
    assign ar_hs = (state == ADDR) && sel_arvalid && m_arready;
    assign beat  = (state == DATA) && m_rvalid && sel_rready;

    assign s0_rdata     = m_rdata;
    assign s1_rdata     = m_rdata;
    assign m_arsize     = 3'b010;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        m_arid     = 4'd0;
        m_araddr   = 32'd0;
        m_arlen    = 8'd0;
        m_arburst  = 2'd0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        s0_rlast   = 1'b0;
        s1_rlast   = 1'b0;
        case (state)
            IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                m_arid     = grant ? S1_ID : S0_ID;
                m_araddr   = grant ? s1_araddr : s0_araddr;
                m_arlen    = sel_arlen;
                m_arburst  = grant ? s1_arburst : s0_arburst;
                m_arvalid  = sel_arvalid;
                s0_arready = !grant && m_arready;
                s1_arready = grant && m_arready;
                if (ar_hs) begin
                    state_next = DATA;
                end else if (!sel_arvalid) begin
                    state_next = IDLE;
                end
            end
            DATA: begin
                s0_rvalid = !grant && m_rvalid;
                s1_rvalid = grant && m_rvalid;
                s0_rlast  = !grant && m_rlast;
                s1_rlast  = grant && m_rlast;
                m_rready  = sel_rready;
                if (beat && m_rlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // beat_cnt counts from 0, so a well-formed burst ends exactly when beat_cnt == len_reg.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            beat_cnt     <= 8'd0;
            len_reg      <= 8'd0;
            protocol_err <= 1'b0;
        end else begin
            if (state == IDLE && (s0_arvalid || s1_arvalid)) begin
                grant <= pick;
            end
            if (ar_hs) begin
                len_reg  <= sel_arlen;
                beat_cnt <= 8'd0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (m_rlast) begin
                    last_grant <= grant;
                    if (beat_cnt != len_reg) begin
                        protocol_err <= 1'b1;
                    end
                end else if (beat_cnt == len_reg) begin
                    protocol_err <= 1'b1;
                end
            end
        end
    end

endmodule
